// File: rtl/pc_fetch.sv
// Instruction-fetch front end: program counter plus a direct-mapped BTB of
// 2-bit saturating counters. Drives the instruction ROM's request side each cycle.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        ce,
  output logic [31:0] pc,
  output logic        pred_taken
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [1:0]       btb_cnt    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [IDX_W-1:0] br_idx;
  logic [TAG_W-1:0] br_tag;
  logic             br_hit;
  logic [31:0]      next_pc;
  logic             unused_bits;

  assign fetch_idx   = pc[IDX_W+1:2];
  assign fetch_tag   = pc[31:IDX_W+2];
  assign fetch_hit   = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
  assign pred_taken  = ce && fetch_hit && btb_cnt[fetch_idx][1];

  assign br_idx      = br_pc[IDX_W+1:2];
  assign br_tag      = br_pc[31:IDX_W+2];
  assign br_hit      = btb_valid[br_idx] && (btb_tag[br_idx] == br_tag);
  assign unused_bits = ^br_pc[1:0];

  // Redirect from EX outranks a stall; prediction only applies to a free-running fetch.
  always_comb begin
    next_pc = pc + 32'd4;
    if (!ce)
      next_pc = RESET_PC;
    else if (redirect)
      next_pc = redirect_pc;
    else if (stall)
      next_pc = pc;
    else if (pred_taken)
      next_pc = btb_target[fetch_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce <= 1'b0;
      pc <= RESET_PC;
    end else begin
      ce <= 1'b1;
      pc <= next_pc;
    end
  end

  // Training is independent of stall/redirect; writes become visible next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_cnt[i]    <= 2'b01;
        btb_target[i] <= 32'h0;
      end
    end else if (br_valid) begin
      if (br_hit) begin
        if (br_taken) begin
          btb_cnt[br_idx]    <= (btb_cnt[br_idx] == 2'b11) ? 2'b11 : btb_cnt[br_idx] + 2'b01;
          btb_target[br_idx] <= br_target;
        end else begin
          btb_cnt[br_idx]    <= (btb_cnt[br_idx] == 2'b00) ? 2'b00 : btb_cnt[br_idx] - 2'b01;
        end
      end else if (br_taken) begin
        btb_valid[br_idx]  <= 1'b1;
        btb_tag[br_idx]    <= br_tag;
        btb_cnt[br_idx]    <= 2'b10;
        btb_target[br_idx] <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch: reset, sequencing, stall/redirect priority,
// BTB allocation, counter hysteresis, tag aliasing, wrap and async reset.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ce;
  logic [31:0] pc;
  logic        pred_taken;

  int n_checks = 0;
  int n_fails  = 0;

  pc_fetch #(.RESET_PC(32'h0000_0000), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .br_valid(br_valid), .br_pc(br_pc),
    .br_taken(br_taken), .br_target(br_target), .ce(ce), .pc(pc),
    .pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                               input logic bv, input logic [31:0] bpc,
                               input logic bt, input logic [31:0] btgt);
    stall = s; redirect = r; redirect_pc = rpc;
    br_valid = bv; br_pc = bpc; br_taken = bt; br_target = btgt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic exp_ce,
                            input logic [31:0] exp_pc, input logic exp_pred);
    checkOutput({tag, ".ce"}, {31'b0, ce}, {31'b0, exp_ce});
    checkOutput({tag, ".pc"}, pc, exp_pc);
    checkOutput({tag, ".pred"}, {31'b0, pred_taken}, {31'b0, exp_pred});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step(); step();
    checkState("reset", 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    checkState("post_release", 1'b0, 32'h0, 1'b0);

    // Sequential fetch
    step(); checkState("seq0", 1'b1, 32'h0, 1'b0);
    step(); checkState("seq4", 1'b1, 32'h4, 1'b0);
    step(); checkState("seq8", 1'b1, 32'h8, 1'b0);
    step(); checkState("seqC", 1'b1, 32'hC, 1'b0);
    step(); checkOutput("seq10", pc, 32'h10);

    // Stall then redirect overriding stall
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkOutput("stall1", pc, 32'h10);
    step(); checkOutput("stall2", pc, 32'h10);
    step(); checkOutput("stall3", pc, 32'h10);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkOutput("redir_over_stall", pc, 32'h200);

    // Allocate 0x8 taken -> 0x40, then refetch from 0
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h40);
    step();
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("restart0", 1'b1, 32'h0, 1'b0);
    idle();
    step(); checkState("alloc_4", 1'b1, 32'h4, 1'b0);
    step(); checkState("alloc_8", 1'b1, 32'h8, 1'b1);
    step(); checkState("alloc_tgt", 1'b1, 32'h40, 1'b0);

    // Saturation and hysteresis: 10 -> 11,11,11 -> 10 (still taken)
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h40);
    step(); step(); step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("hyst_taken", 1'b1, 32'h8, 1'b1);
    idle();
    step(); checkOutput("hyst_tgt", pc, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("hyst_nt", 1'b1, 32'h8, 1'b0);
    idle();
    step(); checkOutput("hyst_fallthru", pc, 32'hC);

    // Aliasing: 0x48 shares index 2 with 0x8 but has a different tag
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h40);
    step();
    applyStimulus(1'b0, 1'b1, 32'h48, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("alias_miss", 1'b1, 32'h48, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h48, 1'b0, 32'h0);
    step(); checkOutput("alias_seq", pc, 32'h4C);
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("alias_kept", 1'b1, 32'h8, 1'b1);

    // Same-cycle training sees the pre-update entry
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0);
    #1; checkOutput("pre_update", {31'b0, pred_taken}, 32'h1);
    step(); checkOutput("pre_update_tgt", pc, 32'h40);

    // Wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    idle();
    step(); checkOutput("wrap_zero", pc, 32'h0);

    // Re-arm 0x8 (01 -> 10), confirm, then async reset mid-cycle
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 32'h40);
    step();
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
    step(); checkState("rearm", 1'b1, 32'h8, 1'b1);
    idle();
    #2 rst = 1'b1;
    #1 checkState("async_rst", 1'b0, 32'h0, 1'b0);
    #1 rst = 1'b0;
    step(); checkState("rst_seq0", 1'b1, 32'h0, 1'b0);
    step(); checkOutput("rst_seq4", pc, 32'h4);
    step(); checkState("rst_cleared", 1'b1, 32'h8, 1'b0);
    step(); checkOutput("rst_fallthru", pc, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end that drives the instruction ROM's request side (`ce`, `addr`, `input_isTaken`) each cycle. It holds the program counter and predicts taken branches with a small direct-mapped branch target buffer of 2-bit saturating counters. It accepts stall and mispredict-redirect from the pipeline and trains the predictor from resolved branches. The ROM echoes the prediction (`output_isTaken`) alongside `inst` into IF/ID.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `IDX_W`, 4, log2 of BTB entries (16 entries)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold PC (from pipeline control)
- `redirect`  in  1  mispredict detected in EX; overrides stall
- `redirect_pc`  in  `InstAddrBus` (32)  correct next fetch address
- `br_valid`  in  1  a branch resolved this cycle (training strobe)
- `br_pc`  in  32  address of the resolved branch
- `br_taken`  in  1  actual direction
- `br_target`  in  32  actual taken target
- `ce`  out  1  ROM chip enable (to ROM `ce`)
- `pc`  out  32  fetch address (to ROM `addr`)
- `pred_taken`  out  1  prediction for `pc` (to ROM `input_isTaken`)

## Operation
- BTB entry: `valid`, `tag` = addr[31:IDX_W+2], `cnt[1:0]`, `target[31:0]`; index = addr[IDX_W+1:2].
- Lookup (combinational on `pc`): `hit` = valid & tag match; `pred_taken` = `ce` & `hit` & `cnt[1]`.
- Next-PC priority:
  1. `!ce`: stay `RESET_PC`.
  2. `redirect`: `redirect_pc`.
  3. `stall`: hold `pc`.
  4. `pred_taken`: entry target.
  5. Otherwise `pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Training on `br_valid` (index/tag from `br_pc`):
  - Hit: `cnt` saturating +1 if taken, −1 if not (floors at 00, caps at 11). On taken, `target <= br_target`.
  - Miss & taken: allocate/overwrite: valid=1, tag, `cnt=2'b10`, `target=br_target`.
  - Miss & not taken: no change.
- Training proceeds regardless of `stall`/`redirect`.
- Low two PC bits are carried as-is; redirects are assumed word-aligned, no check.

## Timing
- Reset (async assert): `pc=RESET_PC`, `ce=0`, `pred_taken=0`, all `valid=0`, all `cnt=2'b01`, targets 0.
- `ce` rises on the first `clk` edge after `rst` deasserts. `pc` stays `RESET_PC` through that edge, so the first fetch is `RESET_PC`.
- `pc` advances one step per edge while `ce=1`. ROM is combinational, so `inst` and `output_isTaken` for `pc` are valid in the same cycle.
- `redirect` at edge N: `pc=redirect_pc` after N. A same-cycle `stall` is ignored.
- BTB writes are visible to lookups from the next cycle. Same-cycle lookup of the same index sees the pre-update entry.
- `rst` mid-operation: all state returns to reset values immediately, independent of `clk`.

## Test plan
- Reset/sequential: assert `rst`, release; expect `ce=0`, `pc=0` for one cycle, then `ce=1`, and `pc` goes 0, 4, 8, 12 on successive edges with `pred_taken=0`.
- Stall/redirect priority: at `pc=0x10`, hold `stall` 3 cycles → `pc` stays 0x10. Then `stall=1`, `redirect=1`, `redirect_pc=0x200` → next `pc=0x200`.
- Allocation and prediction: train `br_pc=0x8`, taken, target 0x40. Restart at 0 → at `pc=0x8`, `pred_taken=1`, next `pc=0x40`.
- Counter saturation/hysteresis: from 2'b10, train taken ×3 (stays 11), then not-taken ×1 → still predicts taken. A second not-taken → predicts not-taken (`pc` 0x8 → 0xC).
- Aliasing/tag: with `IDX_W=4`, allocate 0x8 taken. Fetch 0x48 (same index, different tag) → `pred_taken=0`. Train 0x48 not-taken → entry for 0x8 unchanged.
- Wrap and async reset: `redirect_pc=0xFFFF_FFFC` → next `pc=0`. Assert `rst` mid-cycle → `pc=RESET_PC` and `ce=0` before the next edge, and earlier allocations no longer predict.
